// File: rtl/mem_dma.sv
// mem_dma: single-channel block-copy initiator; master on a word-addressed memory bus.
// Latency: N-word copy accepted at edge t -> done during cycle t+2N+1 (fill: t+N+1).
// Backpressure: none; start is ignored while busy, abort cancels RD/WR at the next edge.
//
// Ports: clk/rst (sync, active-high); start/abort control; src_addr/dst_addr/len
// transfer descriptor (latched on accepted start); busy/done/words_done status;
// mem_en/mem_wr/mem_addr/mem_data_wr/mem_data_rd memory master interface.
// Optional MEM_DMA_FILL_EN adds fill_mode/fill_value: WR-only fill with a constant.
module mem_dma #(
  parameter int DWIDTH = 32,
  parameter int LWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       src_addr,
  input  logic [31:0]       dst_addr,
  input  logic [LWIDTH-1:0] len,
`ifdef MEM_DMA_FILL_EN
  input  logic              fill_mode,
  input  logic [DWIDTH-1:0] fill_value,
`endif
  output logic              busy,
  output logic              done,
  output logic [LWIDTH-1:0] words_done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [31:0]       mem_addr,
  output logic [DWIDTH-1:0] mem_data_wr,
  input  logic [DWIDTH-1:0] mem_data_rd
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       src_q, src_d;
  logic [31:0]       dst_q, dst_d;
  logic [LWIDTH-1:0] len_q, len_d;
  // Word index i doubles as words_done: both count completed writes.
  logic [LWIDTH-1:0] cnt_q, cnt_d;
  logic [DWIDTH-1:0] buf_q, buf_d;
  logic [LWIDTH:0]   cnt_inc;
  logic              last_word;
  logic              is_fill;

`ifdef MEM_DMA_FILL_EN
  logic              fill_q, fill_d;
  logic [DWIDTH-1:0] fill_val_q, fill_val_d;
  assign is_fill = fill_q;
`else
  assign is_fill = 1'b0;
`endif

  // One extra bit so the comparison stays exact at len = 2^LWIDTH-1.
  assign cnt_inc   = {1'b0, cnt_q} + {{LWIDTH{1'b0}}, 1'b1};
  assign last_word = (cnt_inc == {1'b0, len_q});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
`ifdef MEM_DMA_FILL_EN
      fill_q     <= 1'b0;
      fill_val_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
`ifdef MEM_DMA_FILL_EN
      fill_q     <= fill_d;
      fill_val_q <= fill_val_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
`ifdef MEM_DMA_FILL_EN
    fill_d     = fill_q;
    fill_val_d = fill_val_q;
`endif
    case (state_q)
      S_IDLE: begin
        // start beats a simultaneous abort simply because abort is not looked at here.
        if (start) begin
          src_d = src_addr;
          dst_d = dst_addr;
          len_d = len;
          cnt_d = '0;
`ifdef MEM_DMA_FILL_EN
          fill_d     = fill_mode;
          fill_val_d = fill_value;
          if (len == '0)     state_d = S_DONE;
          else if (fill_mode) state_d = S_WR;
          else               state_d = S_RD;
`else
          state_d = (len == '0) ? S_DONE : S_RD;
`endif
        end
      end
      S_RD: begin
        buf_d   = mem_data_rd;
        state_d = abort ? S_IDLE : S_WR;
      end
      S_WR: begin
        // The write strobe is already on the bus this cycle, so it commits and
        // is counted even when abort is asserted.
        cnt_d = cnt_inc[LWIDTH-1:0];
        if (abort)          state_d = S_IDLE;
        else if (last_word) state_d = S_DONE;
        else if (is_fill)   state_d = S_WR;
        else                state_d = S_RD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_data_wr = '0;
    case (state_q)
      S_RD: begin
        mem_en   = 1'b1;
        mem_addr = src_q + 32'(cnt_q);
      end
      S_WR: begin
        mem_en   = 1'b1;
        mem_wr   = 1'b1;
        mem_addr = dst_q + 32'(cnt_q);
`ifdef MEM_DMA_FILL_EN
        mem_data_wr = fill_q ? fill_val_q : buf_q;
`else
        mem_data_wr = buf_q;
`endif
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign words_done = cnt_q;

endmodule

// File: doc/mem_dma.md
Name: mem_dma

Overview:
- Single-channel block-copy initiator that drives the word-addressed memory interface (mem_en / mem_wr / addr / data_rd / data_wr) as bus master.
- The memory responder returns read data combinationally while mem_en=1 and commits writes on the rising clock edge.
- Copies len words from src_addr to dst_addr in ascending order, one read cycle then one write cycle per word.
- Sits between the SoC control logic and the data RAM so blocks can be moved without the core.

Parameters:
- DWIDTH, 32, data word width; must match the memory.
- LWIDTH, 16, width of the transfer length and the word counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  single-cycle request; sampled only in IDLE.
- abort  input  1  synchronous cancel of an active transfer.
- src_addr  input  32  first source word address; latched on accepted start.
- dst_addr  input  32  first destination word address; latched on accepted start.
- len  input  LWIDTH  number of words to copy; latched on accepted start.
- busy  output  1  high in RD, WR and DONE.
- done  output  1  one-cycle pulse when the transfer completes (not on abort).
- words_done  output  LWIDTH  words written so far in the current or last transfer.
- mem_en  output  1  memory enable.
- mem_wr  output  1  memory write strobe; meaningful only with mem_en=1.
- mem_addr  output  32  memory word address.
- mem_data_wr  output  DWIDTH  write data.
- mem_data_rd  input  DWIDTH  read data from memory.

Behaviour:
- Reset is synchronous, active-high; rst has priority over every other input.
- Reset drives the FSM to IDLE and clears all outputs: busy, done, words_done, mem_en, mem_wr, mem_addr and mem_data_wr are all 0. The internal data buffer and address/length registers are also cleared.
- FSM states: IDLE, RD, WR, DONE.
- IDLE:
  - start=1 with len!=0: latch src_addr, dst_addr and len; clear words_done and the index i; go to RD.
  - start=1 with len=0: go directly to DONE; no memory access is made.
  - Otherwise stay in IDLE.
- RD: mem_en=1, mem_wr=0, mem_addr=src+i. At the closing clock edge capture mem_data_rd into the buffer, then go to WR.
- WR: mem_en=1, mem_wr=1, mem_addr=dst+i, mem_data_wr=buffer. At the closing edge increment i and words_done. If i+1==len go to DONE, else go to RD.
- DONE: done=1 for exactly one cycle, busy=1; next state is IDLE.
- Outputs in IDLE: mem_en=0, mem_wr=0, mem_addr=0, mem_data_wr=0. Memory outputs are also 0 in DONE.
- mem_* outputs are decoded from registered state only; there is no combinational path from start to mem_en.
- Latency: an N-word copy accepted at edge t gives done high during cycle t+2N+1. The first mem_en is in cycle t+1.
- Address arithmetic is 32-bit modulo: 0xFFFFFFFF+1 wraps to 0. There is no overlap detection; overlapping regions copy in ascending order.
- len = 2^LWIDTH-1 is legal. words_done never exceeds len.
- start while busy is ignored, including during DONE.
- abort:
  - In RD or WR, abort=1 returns the FSM to IDLE at the next edge with no done pulse. words_done holds the number of completed writes.
  - If abort=1 in a WR cycle, that write still commits (mem_wr was already asserted that cycle) and is counted.
  - abort in IDLE or DONE has no effect.
  - If abort and start are asserted together in IDLE, start wins.
- Reset mid-transfer: the next cycle has mem_en=0 and state IDLE; partial writes already performed remain in memory.

Optional Feature:
- Macro: MEM_DMA_FILL_EN.
- Defined: adds input fill_mode (1 bit) and input fill_value (DWIDTH), both latched on an accepted start.
  - With fill_mode=1, the FSM skips RD and runs WR only: IDLE→WR→WR…→DONE, with mem_data_wr=fill_value and src_addr ignored.
  - An N-word fill gives done in cycle t+N+1.
  - fill_mode=0 behaves exactly as a copy.
- Not defined: the fill_mode and fill_value ports do not exist and the block is copy-only.

Test Plan:
- Reset: hold rst=1 for 3 cycles with start=1 → busy=0, mem_en=0, mem_addr=0, done never asserts; release rst → block stays in IDLE until a fresh start.
- Basic copy: preload RAM[0x10..0x13]=A0,A1,A2,A3; start with src=0x10, dst=0x40, len=4 → 8 alternating RD/WR cycles, RAM[0x40..0x43]=A0..A3, done pulses at cycle t+9, words_done=4.
- Zero length: start with len=0 → no mem_en, done=1 at t+1, words_done=0.
- Abort: len=8, assert abort in the WR cycle of word 2 (i=2) → RAM[dst..dst+2] written, dst+3 untouched, no done pulse, words_done=3, block in IDLE.
- Wrap and ignored start: src=0xFFFFFFFE, dst=0x20, len=3 → reads from 0xFFFFFFFE, 0xFFFFFFFF, 0x0; a start pulse mid-transfer is ignored and done is pulsed once.
- Fill (MEM_DMA_FILL_EN): fill_mode=1, fill_value=0xDEADBEEF, dst=0x80, len=5 → 5 consecutive WR cycles, RAM[0x80..0x84]=0xDEADBEEF, done at t+6.
